// File: rtl/avalon_packetizer_if.sv
// Avalon-ST message interface: framed data with sop/eop/empty and sink backpressure.
// The source drives data, valid, sop, eop and empty; the sink drives rdy.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;
    logic                             rdy;

    modport master (
        output data,
        output valid,
        output sop,
        output eop,
        output empty,
        input  rdy
    );

    modport slave (
        input  data,
        input  valid,
        input  sop,
        input  eop,
        input  empty,
        output rdy
    );
endinterface

// File: rtl/avalon_packetizer.sv
// Transmit-side Avalon-ST framer: turns a byte-length command plus raw payload words
// into sop/eop/empty framed messages, with the unused bytes of the last beat zeroed.
module avalon_packetizer #(
    parameter  int DATA_WIDTH_IN_BYTES = 16,
    parameter  int MAX_MSG_BYTES       = 4096,
    localparam int LEN_W   = ((MAX_MSG_BYTES + 1) > 1) ? $clog2(MAX_MSG_BYTES + 1) : 1,
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    input  logic [LEN_W-1:0]                 cmd_len,
    output logic                             cmd_rdy,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] raw_data,
    input  logic                             raw_valid,
    output logic                             raw_rdy,
    avalon_st_if.master                      msg,
    output logic                             len_error
);

    localparam int W      = DATA_WIDTH_IN_BYTES;
    localparam int DATA_W = W * 8;

    typedef enum logic {
        IDLE,
        IN_MSG
    } state_t;

    state_t             state_q,      state_d;
    logic [LEN_W-1:0]   words_left_q, words_left_d;
    logic [EMPTY_W-1:0] last_empty_q, last_empty_d;
    logic               first_q,      first_d;
    logic               len_error_q,  len_error_d;
    logic               awake_q;

    logic               valid_q, valid_d;
    logic               sop_q,   sop_d;
    logic               eop_q,   eop_d;
    logic [EMPTY_W-1:0] empty_q, empty_d;
    logic [DATA_W-1:0]  data_q,  data_d;

    logic               cmd_fire;
    logic               raw_fire;
    logic               len_illegal;
    logic               last_word;
    logic [LEN_W:0]     len_round;
    logic [LEN_W-1:0]   cmd_words;
    logic [EMPTY_W-1:0] cmd_empty;
    logic [EMPTY_W-1:0] load_empty;

    // Command decode: word count by round-up shift, empty bytes from the low length bits.
    always_comb begin
        len_illegal = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_MSG_BYTES));
        len_round   = (LEN_W + 1)'(cmd_len) + (LEN_W + 1)'(W - 1);
        cmd_words   = LEN_W'(len_round >> EMPTY_W);
        if (W == 1) begin
            cmd_empty = '0;
        end else begin
            cmd_empty = EMPTY_W'(0) - cmd_len[EMPTY_W-1:0];
        end
    end

    // Handshakes: the output register may accept a new word when empty or draining.
    always_comb begin
        cmd_rdy   = awake_q && (state_q == IDLE);
        raw_rdy   = (state_q == IN_MSG) && (!valid_q || msg.rdy);
        cmd_fire  = cmd_valid && cmd_rdy;
        raw_fire  = raw_valid && raw_rdy;
        last_word = (words_left_q == LEN_W'(1));
    end

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        last_empty_d = last_empty_q;
        first_d      = first_q;
        len_error_d  = 1'b0;
        valid_d      = valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        empty_d      = empty_q;
        data_d       = data_q;
        load_empty   = '0;

        if (msg.rdy) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (len_illegal) begin
                        len_error_d = 1'b1;
                    end else begin
                        words_left_d = cmd_words;
                        last_empty_d = cmd_empty;
                        first_d      = 1'b1;
                        state_d      = IN_MSG;
                    end
                end
            end

            IN_MSG: begin
                if (raw_fire) begin
                    load_empty   = last_word ? last_empty_q : '0;
                    valid_d      = 1'b1;
                    sop_d        = first_q;
                    eop_d        = last_word;
                    empty_d      = load_empty;
                    data_d       = raw_data;
                    for (int i = 0; i < W; i++) begin
                        if (i < int'(load_empty)) begin
                            data_d[i*8 +: 8] = 8'h00;
                        end
                    end
                    words_left_d = words_left_q - LEN_W'(1);
                    first_d      = 1'b0;
                    if (last_word) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // awake_q holds cmd_rdy low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            last_empty_q <= '0;
            first_q      <= 1'b0;
            len_error_q  <= 1'b0;
            awake_q      <= 1'b0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            empty_q      <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            last_empty_q <= last_empty_d;
            first_q      <= first_d;
            len_error_q  <= len_error_d;
            awake_q      <= 1'b1;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            empty_q      <= empty_d;
            data_q       <= data_d;
        end
    end

    assign msg.valid = valid_q;
    assign msg.sop   = sop_q;
    assign msg.eop   = eop_q;
    assign msg.empty = empty_q;
    assign msg.data  = data_q;
    assign len_error = len_error_q;

endmodule

// File: tb/tb_avalon_packetizer.sv
// Directed self-checking bench for avalon_packetizer (W=16, MAX_MSG_BYTES=4096).
module tb_avalon_packetizer;

    localparam int W     = 16;
    localparam int LEN_W = 13;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_rdy;
    logic [W*8-1:0]   raw_data;
    logic             raw_valid;
    logic             raw_rdy;
    logic             len_error;

    int checkCount;
    int passCount;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) msg_if ();

    avalon_packetizer #(
        .DATA_WIDTH_IN_BYTES(W),
        .MAX_MSG_BYTES      (4096)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_len  (cmd_len),
        .cmd_rdy  (cmd_rdy),
        .raw_data (raw_data),
        .raw_valid(raw_valid),
        .raw_rdy  (raw_rdy),
        .msg      (msg_if),
        .len_error(len_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkBeat(input string tag, input logic sop, input logic eop,
                             input logic [3:0] empty, input logic [127:0] data);
        checkOutput({tag, ".valid"}, 128'(msg_if.valid), 128'(1'b1));
        checkOutput({tag, ".sop"},   128'(msg_if.sop),   128'(sop));
        checkOutput({tag, ".eop"},   128'(msg_if.eop),   128'(eop));
        checkOutput({tag, ".empty"}, 128'(msg_if.empty), 128'(empty));
        checkOutput({tag, ".data"},  msg_if.data,        data);
    endtask

    task automatic applyStimulus(input logic cv, input logic [LEN_W-1:0] len,
                                 input logic rv, input logic [127:0] data);
        cmd_valid = cv;
        cmd_len   = len;
        raw_valid = rv;
        raw_data  = data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] w;
    logic [127:0] w2;
    logic [127:0] w3;

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b0;
        msg_if.rdy = 1'b1;
        applyStimulus(0, 0, 0, 0);

        // Reset state
        #11;
        checkOutput("rst.valid",     128'(msg_if.valid), 0);
        checkOutput("rst.data",      msg_if.data,        0);
        checkOutput("rst.cmd_rdy",   128'(cmd_rdy),      0);
        checkOutput("rst.raw_rdy",   128'(raw_rdy),      0);
        checkOutput("rst.len_error", 128'(len_error),    0);
        rst = 1'b1;
        #1;
        checkOutput("rel.cmd_rdy_low", 128'(cmd_rdy), 0);
        tick();
        checkOutput("rel.cmd_rdy_high", 128'(cmd_rdy), 1);

        // Single full-width word
        w = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        applyStimulus(1, 16, 0, 0);
        checkOutput("t1.raw_rdy_idle", 128'(raw_rdy), 0);
        tick();
        applyStimulus(0, 0, 1, w);
        checkOutput("t1.raw_rdy", 128'(raw_rdy), 1);
        checkOutput("t1.cmd_rdy", 128'(cmd_rdy), 0);
        checkOutput("t1.novalid", 128'(msg_if.valid), 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkBeat("t1.b1", 1, 1, 0, w);
        checkOutput("t1.cmd_rdy_back", 128'(cmd_rdy), 1);
        tick();
        checkOutput("t1.drain", 128'(msg_if.valid), 0);

        // 40 bytes: three words, last empty=8
        w = {16{8'hAA}};
        applyStimulus(1, 40, 0, 0);
        tick();
        applyStimulus(0, 0, 1, w);
        tick();
        checkBeat("t2.b1", 1, 0, 0, w);
        tick();
        checkBeat("t2.b2", 0, 0, 0, w);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkBeat("t2.b3", 0, 1, 8, 128'hAAAAAAAA_AAAAAAAA_00000000_00000000);
        tick();
        checkOutput("t2.drain", 128'(msg_if.valid), 0);

        // Illegal lengths
        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3.err0", 128'(len_error), 1);
        checkOutput("t3.valid0", 128'(msg_if.valid), 0);
        checkOutput("t3.cmd_rdy0", 128'(cmd_rdy), 1);
        tick();
        checkOutput("t3.err0_end", 128'(len_error), 0);
        applyStimulus(1, 4097, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3.err4097", 128'(len_error), 1);
        checkOutput("t3.cmd_rdy4097", 128'(cmd_rdy), 1);
        tick();
        checkOutput("t3.err4097_end", 128'(len_error), 0);
        checkOutput("t3.valid4097", 128'(msg_if.valid), 0);

        // 64 bytes with a 3-cycle stall on beat 2
        applyStimulus(1, 64, 0, 0);
        tick();
        applyStimulus(0, 0, 1, {16{8'h11}});
        tick();
        checkBeat("t4.b1", 1, 0, 0, {16{8'h11}});
        w2 = {16{8'h12}};
        w3 = {16{8'h13}};
        applyStimulus(0, 0, 1, w2);
        tick();
        checkBeat("t4.b2", 0, 0, 0, w2);
        msg_if.rdy = 1'b0;
        applyStimulus(0, 0, 1, w3);
        checkOutput("t4.stall_rdy", 128'(raw_rdy), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t4.hold_data",  msg_if.data,        w2);
            checkOutput("t4.hold_valid", 128'(msg_if.valid), 1);
            checkOutput("t4.hold_sop",   128'(msg_if.sop),   0);
            checkOutput("t4.hold_rraw",  128'(raw_rdy),      0);
        end
        msg_if.rdy = 1'b1;
        #1;
        checkOutput("t4.resume_rdy", 128'(raw_rdy), 1);
        tick();
        checkBeat("t4.b3", 0, 0, 0, w3);
        applyStimulus(0, 0, 1, {16{8'h14}});
        tick();
        applyStimulus(0, 0, 0, 0);
        checkBeat("t4.b4", 0, 1, 0, {16{8'h14}});
        tick();
        checkOutput("t4.drain", 128'(msg_if.valid), 0);

        // Reset during beat 2 of a 3-word message
        applyStimulus(1, 48, 0, 0);
        tick();
        applyStimulus(0, 0, 1, {16{8'h21}});
        tick();
        applyStimulus(0, 0, 1, {16{8'h22}});
        tick();
        checkBeat("t5.b2", 0, 0, 0, {16{8'h22}});
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("t5.rst_valid",   128'(msg_if.valid), 0);
        checkOutput("t5.rst_data",    msg_if.data,        0);
        checkOutput("t5.rst_sop",     128'(msg_if.sop),   0);
        checkOutput("t5.rst_cmd_rdy", 128'(cmd_rdy),      0);
        checkOutput("t5.rst_raw_rdy", 128'(raw_rdy),      0);
        #3;
        rst = 1'b1;
        tick();
        checkOutput("t5.cmd_rdy", 128'(cmd_rdy), 1);
        applyStimulus(1, 5, 0, 0);
        tick();
        applyStimulus(0, 0, 1, {16{8'h5A}});
        tick();
        applyStimulus(0, 0, 0, 0);
        checkBeat("t5.b1", 1, 1, 11, 128'h5A5A5A5A5A_0000_0000_0000_0000_0000_00);
        tick();
        checkOutput("t5.drain", 128'(msg_if.valid), 0);

        // Back-to-back 17 then 32 with raw_valid held high
        w = {16{8'h33}};
        applyStimulus(1, 17, 1, w);
        tick();
        applyStimulus(1, 32, 1, w);
        checkOutput("t6.cmd_rdy_busy", 128'(cmd_rdy), 0);
        tick();
        checkBeat("t6.b1", 1, 0, 0, w);
        tick();
        checkBeat("t6.b2", 0, 1, 15, {8'h33, 120'h0});
        checkOutput("t6.cmd_rdy_idle", 128'(cmd_rdy), 1);
        tick();
        applyStimulus(0, 0, 1, w);
        checkOutput("t6.gap", 128'(msg_if.valid), 0);
        tick();
        checkBeat("t6.b3", 1, 0, 0, w);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkBeat("t6.b4", 0, 1, 0, w);
        tick();
        checkOutput("t6.drain", 128'(msg_if.valid), 0);
        checkOutput("t6.no_err", 128'(len_error), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
